// File: rtl/sram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sram_pkg : shared widths, port ids and tag record for the ZBT SRAM arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sram_pkg;

  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 32;
  localparam int ZBT_LAT = 2;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_IO  = 1'b1
  } port_id_e;

  typedef struct packed {
    logic              valid;
    logic              we;
    port_id_e          id;
    logic [DATA_W-1:0] wdata;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/sram_arbiter_if.sv
// ----------------------------------------------------------------------------
// sram_arbiter_if : requester handshakes and ZBT SRAM pin-side signals
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sram_arbiter_if
  import sram_pkg::*;
();

  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_gnt;
  logic              r0_rvalid;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_gnt;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r1_rdata;

  logic [ADDR_W-1:0] za;
  logic              xe1;
  logic              xwa;
  logic [DATA_W-1:0] zd_out;
  logic              zd_oe;
  logic [DATA_W-1:0] zd_in;

  // Arbiter side
  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output za, xe1, xwa, zd_out, zd_oe,
    input  zd_in
  );

  // Requester / SRAM side
  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  za, xe1, xwa, zd_out, zd_oe,
    output zd_in
  );

endinterface

`default_nettype wire

// File: rtl/sram_arbiter_tag_pipe.sv
// ----------------------------------------------------------------------------
// sram_tag_pipe : fixed-latency tag shift register, ZD drive and read routing
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_tag_pipe
  import sram_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              xrst,
  input  wire tag_t              issue_tag,
  input  wire logic [DATA_W-1:0] zd_in,
  output logic      [DATA_W-1:0] zd_out,
  output logic                   zd_oe,
  output logic                   r0_rvalid,
  output logic      [DATA_W-1:0] r0_rdata,
  output logic                   r1_rvalid,
  output logic      [DATA_W-1:0] r1_rdata
);

  tag_t              stage_q [ZBT_LAT];
  tag_t              stage_d [ZBT_LAT];
  tag_t              bus_tag;
  logic              zd_oe_q, zd_oe_d;
  logic [DATA_W-1:0] zd_out_q, zd_out_d;
  logic              rd_pend_q, rd_pend_d;
  port_id_e          rd_id_q, rd_id_d;
  logic              r0_rvalid_q, r0_rvalid_d;
  logic              r1_rvalid_q, r1_rvalid_d;
  logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;

  always_comb begin
    stage_d[0] = issue_tag;
    for (int i = 1; i < ZBT_LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end

    // The last stage feeds the registers that are live during the bus cycle.
    bus_tag   = stage_q[ZBT_LAT-1];
    zd_oe_d   = bus_tag.valid & bus_tag.we;
    zd_out_d  = zd_oe_d ? bus_tag.wdata : '0;
    rd_pend_d = bus_tag.valid & ~bus_tag.we;
    rd_id_d   = bus_tag.id;

    // rd_pend_q marks the read's bus cycle; zd_in is sampled at its end.
    r0_rvalid_d = rd_pend_q && (rd_id_q == PORT_CPU);
    r1_rvalid_d = rd_pend_q && (rd_id_q == PORT_IO);
    r0_rdata_d  = r0_rvalid_d ? zd_in : r0_rdata_q;
    r1_rdata_d  = r1_rvalid_d ? zd_in : r1_rdata_q;
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int i = 0; i < ZBT_LAT; i++) begin
        stage_q[i] <= '0;
      end
      zd_oe_q     <= 1'b0;
      zd_out_q    <= '0;
      rd_pend_q   <= 1'b0;
      rd_id_q     <= PORT_CPU;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      for (int i = 0; i < ZBT_LAT; i++) begin
        stage_q[i] <= stage_d[i];
      end
      zd_oe_q     <= zd_oe_d;
      zd_out_q    <= zd_out_d;
      rd_pend_q   <= rd_pend_d;
      rd_id_q     <= rd_id_d;
      r0_rvalid_q <= r0_rvalid_d;
      r1_rvalid_q <= r1_rvalid_d;
      r0_rdata_q  <= r0_rdata_d;
      r1_rdata_q  <= r1_rdata_d;
    end
  end

  assign zd_oe     = zd_oe_q;
  assign zd_out    = zd_out_q;
  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ----------------------------------------------------------------------------
// sram_arbiter : CPU / IO-loader arbiter in front of a pipelined ZBT SRAM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_arbiter
  import sram_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  wire logic     clk,
  input  wire logic     xrst,
  sram_arbiter_if.slave bus
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [ADDR_W-1:0]   za_q, za_d;
  logic                xe1_q, xe1_d;
  logic                xwa_q, xwa_d;
  logic                prio_io;
  logic                gnt0, gnt1;
  tag_t                issue_tag;

  always_comb begin
    prio_io = (starve_q >= STARVE_W'(STARVE_LIMIT));
    // Port 1 only wins a conflict once it has been starved long enough.
    gnt1 = xrst & bus.r1_req & (~bus.r0_req | prio_io);
    gnt0 = xrst & bus.r0_req & ~gnt1;

    if (bus.r1_req && !gnt1) begin
      starve_d = prio_io ? starve_q : starve_q + STARVE_W'(1);
    end else begin
      starve_d = '0;
    end

    za_d      = za_q;
    xe1_d     = 1'b1;
    xwa_d     = 1'b1;
    issue_tag = '0;
    if (gnt0) begin
      za_d      = bus.r0_addr;
      xe1_d     = 1'b0;
      xwa_d     = ~bus.r0_we;
      issue_tag = '{valid: 1'b1, we: bus.r0_we, id: PORT_CPU, wdata: bus.r0_wdata};
    end else if (gnt1) begin
      za_d      = bus.r1_addr;
      xe1_d     = 1'b0;
      xwa_d     = ~bus.r1_we;
      issue_tag = '{valid: 1'b1, we: bus.r1_we, id: PORT_IO, wdata: bus.r1_wdata};
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      starve_q <= '0;
      za_q     <= '0;
      xe1_q    <= 1'b1;
      xwa_q    <= 1'b1;
    end else begin
      starve_q <= starve_d;
      za_q     <= za_d;
      xe1_q    <= xe1_d;
      xwa_q    <= xwa_d;
    end
  end

  assign bus.r0_gnt = gnt0;
  assign bus.r1_gnt = gnt1;
  assign bus.za     = za_q;
  assign bus.xe1    = xe1_q;
  assign bus.xwa    = xwa_q;

  sram_tag_pipe u_tag_pipe (
    .clk       (clk),
    .xrst      (xrst),
    .issue_tag (issue_tag),
    .zd_in     (bus.zd_in),
    .zd_out    (bus.zd_out),
    .zd_oe     (bus.zd_oe),
    .r0_rvalid (bus.r0_rvalid),
    .r0_rdata  (bus.r0_rdata),
    .r1_rvalid (bus.r1_rvalid),
    .r1_rdata  (bus.r1_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_arbiter : scoreboard bench for sram_arbiter with a ZBT SRAM model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sram_arbiter;
  import sram_pkg::*;

  logic clk = 1'b0;
  logic xrst;
  always #5 clk = ~clk;

  sram_arbiter_if bus();

  sram_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus.slave)
  );

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } op_t;
  typedef struct {
    int                due;
    logic [ADDR_W-1:0] addr;
    logic              we;
  } iss_t;
  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } wr_t;
  typedef struct {
    int                due;
    logic              id;
    logic [DATA_W-1:0] data;
  } rd_t;
  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
  } sp_t;

  op_t  q0[$], q1[$];
  iss_t iq[$];
  wr_t  wq[$];
  rd_t  rq[$];
  logic glog[$];
  logic log_en = 1'b0;
  logic last_g0, last_g1;
  int   gcount = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic [DATA_W-1:0] model_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] sram_mem  [logic [ADDR_W-1:0]];
  sp_t sp0, sp1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : '0;
  endfunction

  function automatic logic [DATA_W-1:0] sram_rd(input logic [ADDR_W-1:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : '0;
  endfunction

  // ZBT model: address/control sampled at the edge, data two cycles later.
  always @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      sp0 <= '0;
      sp1 <= '0;
      bus.zd_in <= '0;
    end else begin
      if (sp1.en && sp1.we) sram_mem[sp1.addr] = bus.zd_out;
      bus.zd_in <= (sp0.en && !sp0.we) ? sram_rd(sp0.addr) : '0;
      sp1 <= sp0;
      sp0 <= '{en: !bus.xe1, we: !bus.xwa, addr: bus.za};
    end
  end

  always @(negedge clk) begin
    if (xrst) begin
      check("gnt_onehot", 64'(bus.r0_gnt & bus.r1_gnt), 64'd0);
      if (iq.size() != 0 && iq[0].due == cyc) begin
        check("issue_xe1", 64'(bus.xe1), 64'd0);
        check("issue_xwa", 64'(bus.xwa), 64'(!iq[0].we));
        check("issue_za", 64'(bus.za), 64'(iq[0].addr));
        void'(iq.pop_front());
      end else begin
        check("idle_xe1", 64'(bus.xe1), 64'd1);
        check("idle_xwa", 64'(bus.xwa), 64'd1);
      end
      if (wq.size() != 0 && wq[0].due == cyc) begin
        check("wr_zd_oe", 64'(bus.zd_oe), 64'd1);
        check("wr_zd_out", 64'(bus.zd_out), 64'(wq[0].data));
        void'(wq.pop_front());
      end else begin
        check("idle_zd_oe", 64'(bus.zd_oe), 64'd0);
      end
      if (rq.size() != 0 && rq[0].due == cyc) begin
        if (rq[0].id) begin
          check("r1_rvalid", 64'(bus.r1_rvalid), 64'd1);
          check("r0_rvalid_quiet", 64'(bus.r0_rvalid), 64'd0);
          check("r1_rdata", 64'(bus.r1_rdata), 64'(rq[0].data));
        end else begin
          check("r0_rvalid", 64'(bus.r0_rvalid), 64'd1);
          check("r1_rvalid_quiet", 64'(bus.r1_rvalid), 64'd0);
          check("r0_rdata", 64'(bus.r0_rdata), 64'(rq[0].data));
        end
        void'(rq.pop_front());
      end else begin
        check("idle_rvalid", 64'({bus.r1_rvalid, bus.r0_rvalid}), 64'd0);
      end
    end
  end

  task automatic accept(input logic id, input op_t op);
    gcount++;
    iq.push_back('{due: cyc + 1, addr: op.addr, we: op.we});
    if (op.we) begin
      model_mem[op.addr] = op.data;
      wq.push_back('{due: cyc + 3, data: op.data});
    end else begin
      rq.push_back('{due: cyc + 4, id: id, data: model_rd(op.addr)});
    end
  endtask

  // One bus cycle: present queue heads, observe grants mid-cycle, advance.
  task automatic step();
    op_t op;
    bus.r0_req = (q0.size() != 0);
    if (q0.size() != 0) begin
      bus.r0_we = q0[0].we; bus.r0_addr = q0[0].addr; bus.r0_wdata = q0[0].data;
    end
    bus.r1_req = (q1.size() != 0);
    if (q1.size() != 0) begin
      bus.r1_we = q1[0].we; bus.r1_addr = q1[0].addr; bus.r1_wdata = q1[0].data;
    end
    @(negedge clk);
    last_g0 = bus.r0_gnt;
    last_g1 = bus.r1_gnt;
    if (log_en && bus.r0_req && bus.r1_req) glog.push_back(last_g1);
    if (last_g0 && q0.size() != 0) begin op = q0.pop_front(); accept(1'b0, op); end
    if (last_g1 && q1.size() != 0) begin op = q1.pop_front(); accept(1'b1, op); end
    @(posedge clk);
    #1;
  endtask

  function automatic int busy();
    return q0.size() + q1.size() + iq.size() + wq.size() + rq.size();
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while (busy() != 0 && n < 200) begin
      step();
      n++;
    end
    check(tag, 64'(busy()), 64'd0);
  endtask

  function automatic op_t mk(input logic we, input int a, input logic [DATA_W-1:0] d);
    return '{we: we, addr: ADDR_W'(a), data: d};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_za"}, 64'(bus.za), 64'd0);
    check({tag, "_xe1"}, 64'(bus.xe1), 64'd1);
    check({tag, "_xwa"}, 64'(bus.xwa), 64'd1);
    check({tag, "_zd_oe"}, 64'(bus.zd_oe), 64'd0);
    check({tag, "_zd_out"}, 64'(bus.zd_out), 64'd0);
    check({tag, "_rvalid"}, 64'({bus.r1_rvalid, bus.r0_rvalid}), 64'd0);
    check({tag, "_r0_rdata"}, 64'(bus.r0_rdata), 64'd0);
    check({tag, "_r1_rdata"}, 64'(bus.r1_rdata), 64'd0);
    check({tag, "_starve"}, 64'(dut.starve_q), 64'd0);
    check({tag, "_gnt"}, 64'({bus.r1_gnt, bus.r0_gnt}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g_before;
    xrst = 1'b0;
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    xrst = 1'b1;
    repeat (2) step();

    // Write then read back through port 0
    q0.push_back(mk(1'b1, 'h10, 32'hDEADBEEF));
    q0.push_back(mk(1'b0, 'h10, '0));
    drain("drain_wr_rd");

    // Back-to-back mixed accesses
    q0.push_back(mk(1'b1, 'h1, 32'h11));
    q0.push_back(mk(1'b0, 'h1, '0));
    q0.push_back(mk(1'b1, 'h2, 32'h22));
    q0.push_back(mk(1'b0, 'h2, '0));
    g_before = gcount;
    repeat (4) step();
    check("b2b_grants", 64'(gcount - g_before), 64'd4);
    drain("drain_b2b");

    // Both ports contend continuously
    for (int i = 0; i < 10; i++) q0.push_back(mk(1'b1, 'h100 + i, 32'hA000_0000 + i));
    for (int i = 0; i < 10; i++) q0.push_back(mk(1'b0, 'h100 + i, '0));
    for (int i = 0; i < 3; i++)  q1.push_back(mk(1'b1, 'h200 + i, 32'hB000_0000 + i));
    for (int i = 0; i < 3; i++)  q1.push_back(mk(1'b0, 'h200 + i, '0));
    log_en = 1'b1;
    drain("drain_both");
    log_en = 1'b0;
    check("both_log_len", 64'(glog.size() >= 18), 64'd1);
    for (int k = 0; k < 18 && k < glog.size(); k++) begin
      check("both_gnt_seq", 64'(glog[k]), 64'((k % 9) == 8));
    end

    // Port 1 alone: immediate grant, no starvation build-up
    q1.push_back(mk(1'b1, 'h300, 32'h1234_5678));
    q1.push_back(mk(1'b0, 'h300, '0));
    q1.push_back(mk(1'b0, 'h10, '0));
    for (int i = 0; i < 3; i++) begin
      step();
      check("r1only_gnt", 64'({last_g1, last_g0}), 64'b10);
      check("r1only_starve", 64'(dut.starve_q), 64'd0);
    end
    drain("drain_r1only");

    // Reset during the cycle after a read grant
    q0.push_back(mk(1'b0, 'h10, '0));
    step();
    xrst = 1'b0;
    iq.delete(); wq.delete(); rq.delete();
    bus.r0_req = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    bus.r0_req = 1'b0;
    xrst = 1'b1;
    repeat (6) step();
    q0.push_back(mk(1'b0, 'h10, '0));
    drain("drain_after_rst");

    // Write followed immediately by a read of the same address
    q1.push_back(mk(1'b1, 'h3FF, 32'h5));
    q1.push_back(mk(1'b0, 'h3FF, '0));
    drain("drain_fwd");
    check("fwd_r1_rdata", 64'(bus.r1_rdata), 64'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
